hall_call_panel: RTL and testbench

- Upstream front end for the elevator main controller: conditions raw hall-call push buttons (up/down per floor) into clean, latched pick-up requests.
- Drives the controller's up/down request vectors, which replace the bare random_up/random_down stimulus.
- Accepts service-clear strobes back from the controller.
- Tracks each pending request's wait age and reports the oldest pending call, for dispatch fairness and for liveness checking.

---
 rtl/hall_call_panel.sv | 184 ++++++++++++++++++
 tb/tb_hall_call_panel.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_call_panel.sv
// -----------------------------------------------------------------------------
// hall_call_panel
//
// Front end for the elevator main controller. Each physical hall-call button
// (up/down per floor) is debounced, latched as a level request and held until
// the controller strobes a service clear. A held button must be released
// before it can latch again. Every latched request carries a saturating wait
// age. The panel reports the number of pending requests and the
// longest-waiting one.
//
// Ports
//   clk           system clock, all state changes on posedge
//   reset         synchronous, active-high reset
//   raw_up        raw up-button levels, bit i = floor i
//   raw_down      raw down-button levels, bit i = floor i
//   clr_up        one-cycle service-clear strobes for up requests
//   clr_down      one-cycle service-clear strobes for down requests
//   req_up        latched up requests (level)
//   req_down      latched down requests (level)
//   pending_cnt   number of latched requests
//   oldest_valid  at least one request is latched
//   oldest_floor  floor of the longest-waiting request (0 when none)
//   oldest_dir    direction of that request, 0 = UP, 1 = DOWN (0 when none)
// -----------------------------------------------------------------------------
module hall_call_panel #(
  parameter int FLOORS     = 3,
  parameter int DEB_CYCLES = 2,
  parameter int AGE_W      = 4,
  parameter int FLR_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] raw_up,
  input  logic [FLOORS-1:0] raw_down,
  input  logic [FLOORS-1:0] clr_up,
  input  logic [FLOORS-1:0] clr_down,
  output logic [FLOORS-1:0] req_up,
  output logic [FLOORS-1:0] req_down,
  output logic [FLR_W+1:0]  pending_cnt,
  output logic              oldest_valid,
  output logic [FLR_W-1:0]  oldest_floor,
  output logic              oldest_dir
);

  // Buttons are flattened: index f is up at floor f,
  // and index FLOORS+f is down at floor f.
  localparam int NB    = 2 * FLOORS;
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_LATCHED,
    S_WAIT_RELEASE
  } btn_state_t;

  // Up at the top floor and down at the ground floor do not exist.
  function automatic logic btn_valid(input int b);
    if (b < FLOORS) return (b != FLOORS - 1);
    else            return (b != FLOORS);
  endfunction

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

  logic [NB-1:0]    raw_all;
  logic [NB-1:0]    clr_all;
  logic [NB-1:0]    lat;

  btn_state_t       state_q   [NB];
  btn_state_t       state_nxt [NB];
  logic [CNT_W-1:0] cnt_q     [NB];
  logic [CNT_W-1:0] cnt_nxt   [NB];
  logic [AGE_W-1:0] age_q     [NB];
  logic [AGE_W-1:0] age_nxt   [NB];

  assign raw_all = {raw_down, raw_up};
  assign clr_all = {clr_down, clr_up};

  // State register for all button FSMs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= S_IDLE;
        cnt_q[b]   <= '0;
        age_q[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= state_nxt[b];
        cnt_q[b]   <= cnt_nxt[b];
        age_q[b]   <= age_nxt[b];
      end
    end
  end

  // Next-state logic. A clear strobe blocks any progress toward LATCHED in the
  // same cycle, so a serviced button always ends the cycle OFF.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      state_nxt[b] = state_q[b];
      cnt_nxt[b]   = cnt_q[b];
      age_nxt[b]   = '0;

      if (!btn_valid(b)) begin
        state_nxt[b] = S_IDLE;
        cnt_nxt[b]   = '0;
      end else begin
        case (state_q[b])
          S_IDLE: begin
            cnt_nxt[b] = '0;
            if (!clr_all[b] && raw_all[b]) begin
              if (DEB_CYCLES == 1) begin
                state_nxt[b] = S_LATCHED;
              end else begin
                state_nxt[b] = S_DEBOUNCE;
                cnt_nxt[b]   = CNT_W'(1);
              end
            end
          end
          S_DEBOUNCE: begin
            if (clr_all[b] || !raw_all[b]) begin
              state_nxt[b] = S_IDLE;
              cnt_nxt[b]   = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
              state_nxt[b] = S_LATCHED;
              cnt_nxt[b]   = '0;
            end else begin
              cnt_nxt[b]   = cnt_q[b] + 1'b1;
            end
          end
          S_LATCHED: begin
            cnt_nxt[b] = '0;
            if (clr_all[b]) begin
              state_nxt[b] = raw_all[b] ? S_WAIT_RELEASE : S_IDLE;
            end else begin
              age_nxt[b]   = age_sat_inc(age_q[b]);
            end
          end
          S_WAIT_RELEASE: begin
            cnt_nxt[b] = '0;
            if (!raw_all[b]) state_nxt[b] = S_IDLE;
          end
          default: begin
            state_nxt[b] = S_IDLE;
            cnt_nxt[b]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) lat[b] = (state_q[b] == S_LATCHED);
  end

  assign req_up   = lat[FLOORS-1:0];
  assign req_down = lat[NB-1:FLOORS];

  // Oldest-request arbitration. Scanning floors upward with UP before DOWN and
  // replacing only on a strictly greater age gives the required tie-break.
  always_comb begin
    pending_cnt  = '0;
    oldest_valid = 1'b0;
    oldest_floor = '0;
    oldest_dir   = 1'b0;
    for (int f = 0; f < FLOORS; f++) begin
      for (int d = 0; d < 2; d++) begin
        if (lat[d*FLOORS+f]) begin
          pending_cnt = pending_cnt + 1'b1;
          if (!oldest_valid || (age_q[d*FLOORS+f] > age_q[oldest_dir*FLOORS+int'(oldest_floor)])) begin
            oldest_valid = 1'b1;
            oldest_floor = FLR_W'(f);
            oldest_dir   = 1'(d);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hall_call_panel.sv
module tb_hall_call_panel;

  localparam int F       = 3;
  localparam int DEB     = 2;
  localparam int AGE_W   = 4;
  localparam int FLR_W   = 2;
  localparam int NB      = 2 * F;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [F-1:0]     raw_up = '0, raw_down = '0, clr_up = '0, clr_down = '0;
  logic [F-1:0]     req_up, req_down;
  logic [FLR_W+1:0] pending_cnt;
  logic             oldest_valid;
  logic [FLR_W-1:0] oldest_floor;
  logic             oldest_dir;

  hall_call_panel #(.FLOORS(F), .DEB_CYCLES(DEB), .AGE_W(AGE_W), .FLR_W(FLR_W)) dut (
    .clk(clk), .reset(reset),
    .raw_up(raw_up), .raw_down(raw_down), .clr_up(clr_up), .clr_down(clr_down),
    .req_up(req_up), .req_down(req_down), .pending_cnt(pending_cnt),
    .oldest_valid(oldest_valid), .oldest_floor(oldest_floor), .oldest_dir(oldest_dir)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per button, whether it is latched, its wait age, how many
  // consecutive accepted high samples it has seen, and whether it is waiting
  // for release after being serviced while held.
  int m_lat [NB];
  int m_age [NB];
  int m_run [NB];
  int m_wr  [NB];

  function automatic bit legal(input int b);
    if (b < F) return (b != F - 1);
    return (b != F);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input logic [F-1:0] ru, rd, cu, cd);
    for (int b = 0; b < NB; b++) begin
      bit raw, clr;
      raw = (b < F) ? ru[b] : rd[b-F];
      clr = (b < F) ? cu[b] : cd[b-F];
      if (rst || !legal(b)) begin
        m_lat[b] = 0; m_age[b] = 0; m_run[b] = 0; m_wr[b] = 0;
      end else if (m_lat[b] != 0) begin
        if (clr) begin
          m_lat[b] = 0; m_age[b] = 0; m_wr[b] = raw;
        end else if (m_age[b] < AGE_MAX) begin
          m_age[b]++;
        end
      end else if (m_wr[b] != 0) begin
        if (!raw) m_wr[b] = 0;
      end else if (clr || !raw) begin
        m_run[b] = 0;
      end else begin
        m_run[b]++;
        if (m_run[b] >= DEB) begin
          m_lat[b] = 1; m_age[b] = 0; m_run[b] = 0;
        end
      end
    end
  endtask

  task automatic compare_model();
    int eu, ed, cnt, maxa, ef, edir, found;
    eu = 0; ed = 0; cnt = 0; maxa = -1; ef = 0; edir = 0; found = 0;
    for (int b = 0; b < NB; b++) begin
      if (m_lat[b] != 0) begin
        cnt++;
        if (b < F) eu += (1 << b); else ed += (1 << (b - F));
        if (m_age[b] > maxa) maxa = m_age[b];
      end
    end
    for (int f = 0; f < F; f++)
      for (int d = 0; d < 2; d++)
        if (found == 0 && m_lat[d*F+f] != 0 && m_age[d*F+f] == maxa) begin
          found = 1; ef = f; edir = d;
        end
    chk("model_req_up", req_up, eu);
    chk("model_req_down", req_down, ed);
    chk("model_pending_cnt", pending_cnt, cnt);
    chk("model_oldest_valid", oldest_valid, found);
    chk("model_oldest_floor", oldest_floor, ef);
    chk("model_oldest_dir", oldest_dir, edir);
  endtask

  task automatic step(input bit rst, input logic [F-1:0] ru, rd, cu, cd);
    @(negedge clk);
    reset = rst; raw_up = ru; raw_down = rd; clr_up = cu; clr_down = cd;
    @(posedge clk);
    model_edge(rst, ru, rd, cu, cd);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0);
  endtask

  task automatic exp_oldest(input string name, input int pend, input int v, input int fl, input int dir);
    chk({name, "_pending"}, pending_cnt, pend);
    chk({name, "_valid"}, oldest_valid, v);
    chk({name, "_floor"}, oldest_floor, fl);
    chk({name, "_dir"}, oldest_dir, dir);
  endtask

  typedef struct {
    bit           rst;
    logic [F-1:0] ru, rd, cu, cd, eu, ed;
    int           pend;
    int           v, fl, dir;
  } vec_t;

  function automatic vec_t mk(input bit rst, input logic [F-1:0] ru, rd, cu, cd, eu, ed,
                              input int pend, v, fl, dir);
    vec_t r;
    r.rst = rst; r.ru = ru; r.rd = rd; r.cu = cu; r.cd = cd; r.eu = eu; r.ed = ed;
    r.pend = pend; r.v = v; r.fl = fl; r.dir = dir;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [F-1:0] cur_ru, cur_rd, rcu, rcd;
    bit           rrst;

    //              rst  raw_up  raw_dn  clr_up  clr_dn  req_up  req_dn  pend v fl dir
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 1, 1, 1, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 1, 1, 1, 0));
    tbl.push_back(mk(0, 3'b000, 3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 1, 1, 1, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 1, 1, 1, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 1, 1, 1, 1));
    tbl.push_back(mk(1, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 1, 1, 1, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].ru, tbl[i].rd, tbl[i].cu, tbl[i].cd);
      chk($sformatf("tbl%0d_req_up", i), req_up, tbl[i].eu);
      chk($sformatf("tbl%0d_req_down", i), req_down, tbl[i].ed);
      exp_oldest($sformatf("tbl%0d", i), tbl[i].pend, tbl[i].v, tbl[i].fl, tbl[i].dir);
    end

    // Oldest arbitration: down[1] latched three cycles before up[0].
    step(0, 3'b000, 3'b010, 3'b000, 3'b000);
    step(0, 3'b000, 3'b010, 3'b000, 3'b000);
    step(0, 3'b000, 3'b000, 3'b000, 3'b000);
    step(0, 3'b001, 3'b000, 3'b000, 3'b000);
    step(0, 3'b001, 3'b000, 3'b000, 3'b000);
    exp_oldest("arb_down1_first", 2, 1, 1, 1);
    step(0, 3'b000, 3'b000, 3'b000, 3'b010);
    exp_oldest("arb_after_clr_down1", 1, 1, 0, 0);
    step(0, 3'b000, 3'b000, 3'b001, 3'b000);
    exp_oldest("arb_empty", 0, 0, 0, 0);
    step(0, 3'b010, 3'b010, 3'b000, 3'b000);
    step(0, 3'b010, 3'b010, 3'b000, 3'b000);
    exp_oldest("arb_tie_same_floor", 2, 1, 1, 0);
    step(0, 3'b000, 3'b000, 3'b010, 3'b010);
    exp_oldest("arb_cleared", 0, 0, 0, 0);

    // Age saturation: down[2] saturates long before up[0] latches.
    step(0, 3'b000, 3'b100, 3'b000, 3'b000);
    step(0, 3'b000, 3'b100, 3'b000, 3'b000);
    idle(40);
    exp_oldest("sat_single", 1, 1, 2, 1);
    step(0, 3'b001, 3'b000, 3'b000, 3'b000);
    step(0, 3'b001, 3'b000, 3'b000, 3'b000);
    exp_oldest("sat_young_up0", 2, 1, 2, 1);
    idle(10);
    exp_oldest("sat_up0_age10", 2, 1, 2, 1);
    idle(10);
    exp_oldest("sat_both_max_tie", 2, 1, 0, 0);
    idle(20);
    exp_oldest("sat_still_tie", 2, 1, 0, 0);
    step(0, 3'b000, 3'b000, 3'b001, 3'b100);
    exp_oldest("sat_cleared", 0, 0, 0, 0);

    // Reset with three requests latched and buttons still held.
    step(0, 3'b011, 3'b100, 3'b000, 3'b000);
    step(0, 3'b011, 3'b100, 3'b000, 3'b000);
    exp_oldest("rst_three_latched", 3, 1, 0, 0);
    step(1, 3'b011, 3'b100, 3'b000, 3'b000);
    chk("rst_req_up", req_up, 0);
    chk("rst_req_down", req_down, 0);
    exp_oldest("rst_outputs", 0, 0, 0, 0);
    step(0, 3'b011, 3'b100, 3'b000, 3'b000);
    exp_oldest("rst_fresh_debounce", 0, 0, 0, 0);
    step(0, 3'b011, 3'b100, 3'b000, 3'b000);
    chk("rst_relatch_up", req_up, 3'b011);
    chk("rst_relatch_down", req_down, 3'b100);
    exp_oldest("rst_relatch", 3, 1, 0, 0);
    step(0, 3'b000, 3'b000, 3'b011, 3'b100);
    exp_oldest("rst_final_clear", 0, 0, 0, 0);

    // Randomized traffic checked every cycle against the model.
    cur_ru = '0;
    cur_rd = '0;
    for (int n = 0; n < 3000; n++) begin
      rcu = '0;
      rcd = '0;
      for (int f = 0; f < F; f++) begin
        if ($urandom_range(0, 3) == 0) cur_ru[f] = ~cur_ru[f];
        if ($urandom_range(0, 3) == 0) cur_rd[f] = ~cur_rd[f];
        if ($urandom_range(0, 4) == 0 && (m_lat[f] != 0 || m_wr[f] != 0 || m_run[f] != 0))
          rcu[f] = 1'b1;
        if ($urandom_range(0, 4) == 0 && (m_lat[F+f] != 0 || m_wr[F+f] != 0 || m_run[F+f] != 0))
          rcd[f] = 1'b1;
      end
      rrst = ($urandom_range(0, 299) == 0);
      step(rrst, cur_ru, cur_rd, rcu, rcd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
